// File: rtl/logger_pkg.sv
// Shared constants, field-size helpers and parser state type for the UART logger line format.
package logger_pkg;

  localparam logic [7:0] ASC_COMMA = 8'h2C;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;

  typedef enum logic [2:0] {
    S_ID,
    S_START,
    S_END,
    S_DELTA,
    S_EOL,
    S_RESYNC
  } parser_state_t;

  function automatic int unsigned id_nib(input int unsigned id_w);
    return (id_w + 3) / 4;
  endfunction

  function automatic int unsigned ts_nib(input int unsigned ts_w);
    return (ts_w + 3) / 4;
  endfunction

endpackage

// File: rtl/ascii_hex_decode.sv
// Combinational ASCII hex digit decoder: accepts 0-9, A-F, a-f.
module ascii_hex_decode (
  input  logic [7:0] data,
  output logic       is_hex,
  output logic [3:0] nib
);

  always_comb begin
    is_hex = 1'b0;
    nib    = 4'h0;
    if (data >= 8'h30 && data <= 8'h39) begin
      is_hex = 1'b1;
      nib    = data[3:0];
    end else if ((data >= 8'h41 && data <= 8'h46) || (data >= 8'h61 && data <= 8'h66)) begin
      // Low nibble of 'A'/'a' is 1, so add 9 to land on 10.
      is_hex = 1'b1;
      nib    = data[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/logger_line_parser.sv
// Decodes ASCII-hex CSV logger lines "ID,START,END,DELTA\r\n" back into event records.
module logger_line_parser
  import logger_pkg::*;
#(
  parameter int unsigned ID_W  = 16,
  parameter int unsigned TS_W  = 64,
  parameter int unsigned ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ID_W-1:0]  out_id,
  output logic [TS_W-1:0]  out_start,
  output logic [TS_W-1:0]  out_end,
  output logic [TS_W-1:0]  out_delta,
  output logic             out_chk_ok,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int unsigned ID_NIB  = id_nib(ID_W);
  localparam int unsigned TS_NIB  = ts_nib(TS_W);
  localparam int unsigned MAX_NIB = (ID_NIB > TS_NIB) ? ID_NIB : TS_NIB;
  localparam int unsigned CNT_W   = $clog2(MAX_NIB + 1);

  parser_state_t    state;
  logic [CNT_W-1:0] cnt;
  logic [ID_W-1:0]  id_f;
  logic [TS_W-1:0]  start_f, end_f, delta_f;
  logic [TS_W-1:0]  diff;

  logic             is_hex;
  logic [3:0]       nib;
  logic             is_comma, is_cr, is_lf;
  logic             take;
  logic [CNT_W-1:0] need;
  logic             full, sep_ok;
  logic             digit, adv, commit, err;

  ascii_hex_decode u_hex (
    .data   (in_data),
    .is_hex (is_hex),
    .nib    (nib)
  );

  assign in_ready = ~out_valid;
  assign take     = in_valid & in_ready;
  assign is_comma = (in_data == ASC_COMMA);
  assign is_cr    = (in_data == ASC_CR);
  assign is_lf    = (in_data == ASC_LF);
  assign diff     = end_f - start_f;

  always_comb begin
    need   = (state == S_ID) ? CNT_W'(ID_NIB) : CNT_W'(TS_NIB);
    full   = (cnt == need);
    sep_ok = (state == S_DELTA) ? (is_cr | is_lf) : is_comma;
    digit  = 1'b0;
    adv    = 1'b0;
    commit = 1'b0;
    err    = 1'b0;
    if (take) begin
      case (state)
        S_ID, S_START, S_END, S_DELTA: begin
          if (is_hex && !full) begin
            digit = 1'b1;
          end else if (full && sep_ok) begin
            if (state == S_DELTA && is_lf) commit = 1'b1;
            else                           adv    = 1'b1;
          end else begin
            err = 1'b1;
          end
        end
        S_EOL: begin
          if (is_lf) commit = 1'b1;
          else       err    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_ID;
      cnt        <= '0;
      id_f       <= '0;
      start_f    <= '0;
      end_f      <= '0;
      delta_f    <= '0;
      out_valid  <= 1'b0;
      out_id     <= '0;
      out_start  <= '0;
      out_end    <= '0;
      out_delta  <= '0;
      out_chk_ok <= 1'b0;
      err_pulse  <= 1'b0;
      err_cnt    <= '0;
    end else begin
      err_pulse <= err;
      if (err && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      if (out_valid && out_ready) out_valid <= 1'b0;

      if (digit) begin
        cnt <= cnt + 1'b1;
        case (state)
          S_ID:    id_f    <= ID_W'({id_f, nib});
          S_START: start_f <= TS_W'({start_f, nib});
          S_END:   end_f   <= TS_W'({end_f, nib});
          default: delta_f <= TS_W'({delta_f, nib});
        endcase
      end

      if (adv) begin
        cnt <= '0;
        case (state)
          S_ID:    state <= S_START;
          S_START: state <= S_END;
          S_END:   state <= S_DELTA;
          default: state <= S_EOL;
        endcase
      end

      if (commit) begin
        cnt        <= '0;
        state      <= S_ID;
        out_valid  <= 1'b1;
        out_id     <= id_f;
        out_start  <= start_f;
        out_end    <= end_f;
        out_delta  <= delta_f;
        out_chk_ok <= (delta_f == diff);
      end

      // An offending '\n' already ends the line, so no resync is needed.
      if (err) begin
        cnt   <= '0;
        state <= is_lf ? S_ID : S_RESYNC;
      end

      if (take && state == S_RESYNC && is_lf) state <= S_ID;
    end
  end

endmodule

// File: tb/tb_logger_line_parser.sv
// Directed bench for logger_line_parser; ERR_W is shrunk to 4 so saturation is reachable quickly.
module tb_logger_line_parser;

  localparam int unsigned ID_W  = 16;
  localparam int unsigned TS_W  = 64;
  localparam int unsigned ERR_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_data = 8'h00;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ID_W-1:0]  out_id;
  logic [TS_W-1:0]  out_start, out_end, out_delta;
  logic             out_chk_ok;
  logic             err_pulse;
  logic [ERR_W-1:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;
  int hs       = 0;
  int snap_p, snap_h;

  logger_line_parser #(.ID_W(ID_W), .TS_W(TS_W), .ERR_W(ERR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_id     (out_id),
    .out_start  (out_start),
    .out_end    (out_end),
    .out_delta  (out_delta),
    .out_chk_ok (out_chk_ok),
    .err_pulse  (err_pulse),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err_pulse) pulses++;
    if (out_valid && out_ready) hs++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  // Ends just after the '\n' edge: a committed record is visible right then.
  task automatic send_line(input string s, input bit cr);
    send_str(s);
    if (cr) send_byte(8'h0D);
    chk("valid_before_lf", {63'd0, out_valid}, 64'd0);
    send_byte(8'h0A);
  endtask

  task automatic chk_rec(input string tag, input logic [63:0] id, input logic [63:0] st,
                         input logic [63:0] en, input logic [63:0] de, input logic ok);
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_id"}, {48'd0, out_id}, id);
    chk({tag, "_start"}, out_start, st);
    chk({tag, "_end"}, out_end, en);
    chk({tag, "_delta"}, out_delta, de);
    chk({tag, "_chk_ok"}, {63'd0, out_chk_ok}, {63'd0, ok});
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_err_cnt", {60'd0, err_cnt}, 64'd0);
    chk("rst_err_pulse", {63'd0, err_pulse}, 64'd0);
    chk("rst_out_id", {48'd0, out_id}, 64'd0);

    // 1: basic CRLF line
    send_line("0001,0000000000000010,0000000000000025,0000000000000015", 1'b1);
    chk_rec("t1", 64'h0001, 64'h10, 64'h25, 64'h15, 1'b1);

    // 2: lowercase, LF only, wrap-around delta, then a delta mismatch
    send_line("00ab,fffffffffffffff0,0000000000000010,0000000000000020", 1'b0);
    chk_rec("t2a", 64'h00AB, 64'hFFFFFFFFFFFFFFF0, 64'h10, 64'h20, 1'b1);
    send_line("00ab,fffffffffffffff0,0000000000000010,0000000000000021", 1'b0);
    chk_rec("t2b", 64'h00AB, 64'hFFFFFFFFFFFFFFF0, 64'h10, 64'h21, 1'b0);
    settle();
    chk("t2_err_cnt", {60'd0, err_cnt}, 64'd0);

    // 3: non-hex digit drops the line, next line intact
    snap_p = pulses;
    snap_h = hs;
    send_line("0002,00G0000000000001,0000000000000002,0000000000000001", 1'b1);
    settle();
    chk("t3_pulses", 64'(pulses - snap_p), 64'd1);
    chk("t3_err_cnt", {60'd0, err_cnt}, 64'd1);
    chk("t3_no_record", 64'(hs - snap_h), 64'd0);
    send_line("1234,0000000000000100,0000000000000200,0000000000000100", 1'b1);
    chk_rec("t3", 64'h1234, 64'h100, 64'h200, 64'h100, 1'b1);

    // 4: short field, extra digit, '\n' as offender, empty line
    send_line("0003,000000000000001,0000000000000002,0000000000000001", 1'b1);
    settle();
    chk("t4_short", {60'd0, err_cnt}, 64'd2);
    send_line("0004,00000000000000001,0000000000000002,0000000000000001", 1'b1);
    settle();
    chk("t4_extra", {60'd0, err_cnt}, 64'd3);
    snap_h = hs;
    send_line("0005,00", 1'b0);
    send_byte(8'h0A);
    settle();
    chk("t4_lf_err", {60'd0, err_cnt}, 64'd5);
    send_line("BEEF,00000000DEADBEEF,00000000DEADBEF0,0000000000000001", 1'b1);
    chk_rec("t4", 64'hBEEF, 64'hDEADBEEF, 64'hDEADBEF0, 64'h1, 1'b1);
    settle();
    chk("t4_records", 64'(hs - snap_h), 64'd1);

    // 5: backpressure holds record and blocks input
    out_ready = 1'b0;
    send_line("00c5,0123456789abcdef,0123456789abcdf0,0000000000000001", 1'b1);
    chk_rec("t5a", 64'h00C5, 64'h0123456789ABCDEF, 64'h0123456789ABCDF0, 64'h1, 1'b1);
    in_valid = 1'b1;
    in_data  = "0";
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1 || i == 20) begin
        chk("t5_in_ready", {63'd0, in_ready}, 64'd0);
        chk("t5_hold_id", {48'd0, out_id}, 64'h00C5);
        chk("t5_hold_end", out_end, 64'h0123456789ABCDF0);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_valid_drop", {63'd0, out_valid}, 64'd0);
    chk("t5_ready_back", {63'd0, in_ready}, 64'd1);
    send_line("0777,0000000000000005,0000000000000003,fffffffffffffffe", 1'b1);
    chk_rec("t5b", 64'h0777, 64'h5, 64'h3, 64'hFFFFFFFFFFFFFFFE, 1'b1);
    settle();
    chk("t5_err_cnt", {60'd0, err_cnt}, 64'd5);

    // 6: reset mid-line, then saturation
    send_str("0006,00000");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("t6_rst_id", {48'd0, out_id}, 64'd0);
    chk("t6_rst_delta", out_delta, 64'd0);
    chk("t6_rst_err_cnt", {60'd0, err_cnt}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t6_in_ready", {63'd0, in_ready}, 64'd1);
    send_line("00000000010,0000000000000020,0000000000000010", 1'b1);
    settle();
    chk("t6_tail_err", {60'd0, err_cnt}, 64'd1);
    send_line("FFFF,FFFFFFFFFFFFFFFF,0000000000000000,0000000000000001", 1'b1);
    chk_rec("t6", 64'hFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h1, 1'b1);
    snap_p = pulses;
    for (int i = 0; i < 14; i++) send_byte(8'h0A);
    settle();
    chk("t6_sat_reach", {60'd0, err_cnt}, 64'd15);
    send_byte(8'h0A);
    settle();
    chk("t6_sat_hold", {60'd0, err_cnt}, 64'd15);
    chk("t6_sat_pulses", 64'(pulses - snap_p), 64'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
